multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multicycle control FSM: drives aluc/ena of the 32-bit ALU and consumes its zero/overflow flags.
//  Sequences FETCH->DECODE->EXEC->MEM->WB per instruction and emits all datapath strobes/selects.
//  Also generates the memory handshake for the shared instruction/data port.
//  Supports the ALU-class MIPS subset plus lw/sw, beq/bne, j/jal/jr.
// PARAMETERS
//  WAIT_W      8    width of the mem_ready wait counter
//  WAIT_LIMIT  255  cycles without mem_ready before bus_err; 0 = wait forever
// PORTS
//  clk           in   1   clock, all state changes on rising edge
//  rst           in   1   synchronous, active-high reset
//  instr         in   32  IR contents (valid from DECODE onward)
//  mem_ready     in   1   memory completes the access this cycle
//  alu_zero      in   1   ALU zero flag
//  alu_overflow  in   1   ALU signed-overflow flag
//  pc_we         out  1   write PC
//  pc_src        out  2   00 PC+4, 01 branch target, 10 jump target, 11 rs
//  ir_we         out  1   load IR from memory data
//  mem_rd        out  1   memory read request
//  mem_wr        out  1   memory write request
//  mem_addr_sel  out  1   0 PC, 1 ALUOut
//  mdr_we        out  1   load MDR
//  aluout_we     out  1   load ALUOut
//  alu_ena       out  1   ALU enable
//  aluc          out  4   ALU op code
//  alu_a_sel     out  1   0 rs, 1 shamt (zero-extended)
//  alu_b_sel     out  2   00 rt, 01 sign-ext imm, 10 zero-ext imm
//  rf_we         out  1   register-file write
//  reg_dst       out  2   00 rt, 01 rd, 10 r31
//  wb_sel        out  2   00 ALUOut, 01 MDR, 10 PC
//  illegal       out  1   1-cycle pulse: undecodable instr
//  bus_err       out  1   1-cycle pulse: wait timeout
//  state_o       out  3   current state (debug)
// BEHAVIOUR
//  - States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4. Outputs are a combinational decode of state+instr.
//  - rst=1: state<=FETCH, wait counter<=0. All outputs 0 while rst=1. mem_rd rises the first cycle after rst drops.
//  - FETCH: mem_rd=1, addr_sel=0. On mem_ready: ir_we=1, pc_we=1 (pc_src=00), then DECODE.
//  - DECODE (1 cycle):
//      j:   pc_we, pc_src=10 -> FETCH
//      jal: also rf_we, reg_dst=10, wb_sel=10 (link = PC+4, no delay slot) -> FETCH
//      jr:  pc_we, pc_src=11 -> FETCH
//      illegal: pulse illegal -> FETCH, no state change
//      all other ops -> EXEC
//  - EXEC: alu_ena=1 and aluc per table.
//      beq/bne: aluc=0011. pc_we=1, pc_src=01 iff zero (beq) / !zero (bne) -> FETCH
//      lw/sw: aluc=0000, b=01, aluout_we -> MEM
//      ALU ops: aluout_we -> WB
//  - aluc table:
//      add/addi 0010, addu/addiu 0000, sub 0011, subu 0001, and/andi 0100, or/ori 0101
//      xor/xori 0110, nor 0111, lui 1000, slt/slti 1011, sltu/sltiu 1010
//      sll/sllv 1110, srl/srlv 1101, sra/srav 1100
//  - Operand selects:
//      shifts: b=rt. sll/srl/sra a=1 (shamt); *v forms a=0 (rs)
//      andi/ori/xori/lui: b=10; other imm ops: b=01
//  - MEM: mem_addr_sel=1.
//      lw: mem_rd until mem_ready, then mdr_we -> WB
//      sw: mem_wr until mem_ready -> FETCH
//  - WB: rf_we=1 -> FETCH.
//      R-type: reg_dst=01, wb_sel=00; I-type ALU: reg_dst=00, wb_sel=00; lw: reg_dst=00, wb_sel=01
//  - Handshake: rd/wr stay asserted, state frozen, until mem_ready. mem_ready outside FETCH/MEM is ignored.
//  - Wait counter: counts cycles in FETCH/MEM without ready; clears on ready or state change.
//      WAIT_LIMIT!=0 and count==WAIT_LIMIT: pulse bus_err, drop request, -> FETCH (PC unchanged).
//  - rst mid-instruction: abandons it; no pc_we/rf_we/mem_wr in the reset cycle.
// CONFIGURATION
//  OVF_TRAP_EN defined:
//      alu_overflow sampled in EXEC for add/addi/sub only.
//      If set: WB skipped (no rf_we), exc_ovf (out,1) pulses 1 cycle -> FETCH.
//  OVF_TRAP_EN undefined: exc_ovf port absent; overflow ignored, writeback always occurs.
// TESTING
//  1. rst 3 cycles, mem_ready=1 always -> mem_rd=1 first cycle after rst; states cycle 0,1,2,4,0 for addu (instr 0x00851021).
//  2. lw 0x8C830004, mem_ready delayed 3 cycles in MEM -> mem_rd held 3 cycles, mdr_we 1 cycle, rf_we with wb_sel=01, reg_dst=00.
//  3. beq 0x10850003 with alu_zero=1 -> aluc=0011, pc_we=1, pc_src=01 in EXEC; with alu_zero=0 -> pc_we=0.
//  4. sll 0x00041080 -> aluc=1110, alu_a_sel=1, alu_b_sel=00; lui 0x3C011234 -> aluc=1000, alu_b_sel=10.
//  5. WAIT_LIMIT=4, mem_ready=0 in FETCH -> bus_err pulses after 4 wait cycles, FETCH restarts, no pc_we.
//  6. OVF_TRAP_EN, add with alu_overflow=1 -> exc_ovf pulse, rf_we stays 0; rst during MEM sw -> mem_wr=0 same cycle.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller for a 32-bit MIPS-subset datapath.
// Optional macro OVF_TRAP_EN: traps signed overflow of add/addi/sub (adds exc_ovf, skips WB).
//
// state  | meaning
// FETCH  | read instruction over shared port, load IR, PC <= PC+4
// DECODE | classify instruction; j/jal/jr complete here
// EXEC   | ALU operation, branch resolve, lw/sw address calculation
// MEM    | lw/sw data access over shared port
// WB     | register-file write
module multicycle_ctrl_fsm #(
    parameter int WAIT_W     = 8,
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        ir_we,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_addr_sel,
    output logic        mdr_we,
    output logic        aluout_we,
    output logic        alu_ena,
    output logic [3:0]  aluc,
    output logic        alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic        rf_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        bus_err,
`ifdef OVF_TRAP_EN
    output logic        exc_ovf,
`endif
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [WAIT_W-1:0] LIMIT_CNT  = WAIT_W'(WAIT_LIMIT);
    localparam bit                TIMEOUT_EN = (WAIT_LIMIT != 0);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              timeout;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_rtype, is_j, is_jal, is_jr, is_beq, is_bne, is_lw, is_sw, is_ill;
    logic       ovf_op, a_shamt;
    logic [3:0] dec_aluc;
    logic [1:0] dec_bsel;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

`ifdef OVF_TRAP_EN
    logic unused_bits;
    assign unused_bits = ^instr[25:6];
`else
    logic unused_bits;
    assign unused_bits = ^{instr[25:6], alu_overflow, ovf_op};
`endif

    always_comb begin
        is_rtype = 1'b0;
        is_j     = 1'b0;
        is_jal   = 1'b0;
        is_jr    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_ill   = 1'b0;
        ovf_op   = 1'b0;
        a_shamt  = 1'b0;
        dec_aluc = 4'b0000;
        dec_bsel = 2'b00;
        case (opcode)
            6'h00: begin
                is_rtype = 1'b1;
                case (funct)
                    6'h00: begin dec_aluc = 4'b1110; a_shamt = 1'b1; end
                    6'h02: begin dec_aluc = 4'b1101; a_shamt = 1'b1; end
                    6'h03: begin dec_aluc = 4'b1100; a_shamt = 1'b1; end
                    6'h04: dec_aluc = 4'b1110;
                    6'h06: dec_aluc = 4'b1101;
                    6'h07: dec_aluc = 4'b1100;
                    6'h08: is_jr = 1'b1;
                    6'h20: begin dec_aluc = 4'b0010; ovf_op = 1'b1; end
                    6'h21: dec_aluc = 4'b0000;
                    6'h22: begin dec_aluc = 4'b0011; ovf_op = 1'b1; end
                    6'h23: dec_aluc = 4'b0001;
                    6'h24: dec_aluc = 4'b0100;
                    6'h25: dec_aluc = 4'b0101;
                    6'h26: dec_aluc = 4'b0110;
                    6'h27: dec_aluc = 4'b0111;
                    6'h2a: dec_aluc = 4'b1011;
                    6'h2b: dec_aluc = 4'b1010;
                    default: is_ill = 1'b1;
                endcase
            end
            6'h02: is_j   = 1'b1;
            6'h03: is_jal = 1'b1;
            6'h04: begin is_beq = 1'b1; dec_aluc = 4'b0011; end
            6'h05: begin is_bne = 1'b1; dec_aluc = 4'b0011; end
            6'h08: begin dec_aluc = 4'b0010; dec_bsel = 2'b01; ovf_op = 1'b1; end
            6'h09: begin dec_aluc = 4'b0000; dec_bsel = 2'b01; end
            6'h0a: begin dec_aluc = 4'b1011; dec_bsel = 2'b01; end
            6'h0b: begin dec_aluc = 4'b1010; dec_bsel = 2'b01; end
            6'h0c: begin dec_aluc = 4'b0100; dec_bsel = 2'b10; end
            6'h0d: begin dec_aluc = 4'b0101; dec_bsel = 2'b10; end
            6'h0e: begin dec_aluc = 4'b0110; dec_bsel = 2'b10; end
            6'h0f: begin dec_aluc = 4'b1000; dec_bsel = 2'b10; end
            6'h23: begin is_lw = 1'b1; dec_aluc = 4'b0000; dec_bsel = 2'b01; end
            6'h2b: begin is_sw = 1'b1; dec_aluc = 4'b0000; dec_bsel = 2'b01; end
            default: is_ill = 1'b1;
        endcase
    end

    // Counter saturates so WAIT_LIMIT=0 (wait forever) never wraps.
    assign wait_next = (wait_cnt == {WAIT_W{1'b1}}) ? wait_cnt : wait_cnt + WAIT_W'(1);
    assign timeout   = TIMEOUT_EN && (wait_cnt == LIMIT_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (timeout) begin
                        wait_cnt <= '0;
                    end else if (mem_ready) begin
                        wait_cnt <= '0;
                        state    <= DECODE;
                    end else begin
                        wait_cnt <= wait_next;
                    end
                end
                DECODE: begin
                    wait_cnt <= '0;
                    state    <= (is_j || is_jal || is_jr || is_ill) ? FETCH : EXEC;
                end
                EXEC: begin
                    wait_cnt <= '0;
                    if (is_beq || is_bne)
                        state <= FETCH;
                    else if (is_lw || is_sw)
                        state <= MEM;
`ifdef OVF_TRAP_EN
                    else if (ovf_op && alu_overflow)
                        state <= FETCH;
`endif
                    else
                        state <= WB;
                end
                MEM: begin
                    if (timeout) begin
                        wait_cnt <= '0;
                        state    <= FETCH;
                    end else if (mem_ready) begin
                        wait_cnt <= '0;
                        state    <= is_lw ? WB : FETCH;
                    end else begin
                        wait_cnt <= wait_next;
                    end
                end
                WB: begin
                    wait_cnt <= '0;
                    state    <= FETCH;
                end
                default: begin
                    wait_cnt <= '0;
                    state    <= FETCH;
                end
            endcase
        end
    end

    // Strobes depend on mem_ready/alu_zero in the same cycle, so they are decoded, not registered.
    always_comb begin
        pc_we        = 1'b0;
        pc_src       = 2'b00;
        ir_we        = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr_sel = 1'b0;
        mdr_we       = 1'b0;
        aluout_we    = 1'b0;
        alu_ena      = 1'b0;
        aluc         = 4'b0000;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 2'b00;
        rf_we        = 1'b0;
        reg_dst      = 2'b00;
        wb_sel       = 2'b00;
        illegal      = 1'b0;
        bus_err      = 1'b0;
`ifdef OVF_TRAP_EN
        exc_ovf      = 1'b0;
`endif
        if (!rst) begin
            case (state)
                FETCH: begin
                    if (timeout) begin
                        bus_err = 1'b1;
                    end else begin
                        mem_rd = 1'b1;
                        if (mem_ready) begin
                            ir_we = 1'b1;
                            pc_we = 1'b1;
                        end
                    end
                end
                DECODE: begin
                    if (is_ill) begin
                        illegal = 1'b1;
                    end else if (is_j) begin
                        pc_we  = 1'b1;
                        pc_src = 2'b10;
                    end else if (is_jal) begin
                        pc_we   = 1'b1;
                        pc_src  = 2'b10;
                        rf_we   = 1'b1;
                        reg_dst = 2'b10;
                        wb_sel  = 2'b10;
                    end else if (is_jr) begin
                        pc_we  = 1'b1;
                        pc_src = 2'b11;
                    end
                end
                EXEC: begin
                    alu_ena   = 1'b1;
                    aluc      = dec_aluc;
                    alu_a_sel = a_shamt;
                    alu_b_sel = dec_bsel;
                    if (is_beq || is_bne) begin
                        pc_we  = is_beq ? alu_zero : !alu_zero;
                        pc_src = 2'b01;
                    end else begin
                        aluout_we = 1'b1;
`ifdef OVF_TRAP_EN
                        exc_ovf = ovf_op && alu_overflow;
`endif
                    end
                end
                MEM: begin
                    mem_addr_sel = 1'b1;
                    if (timeout) begin
                        bus_err = 1'b1;
                    end else begin
                        mem_rd = is_lw;
                        mem_wr = is_sw;
                        mdr_we = is_lw && mem_ready;
                    end
                end
                WB: begin
                    rf_we   = 1'b1;
                    reg_dst = is_lw ? 2'b00 : (is_rtype ? 2'b01 : 2'b00);
                    wb_sel  = is_lw ? 2'b01 : 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign state_o = rst ? 3'd0 : state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm: a table-driven instruction model expands each
// instruction into its expected per-cycle strobe trace, which is replayed against the DUT.
`timescale 1ns/1ps
module tb_multicycle_ctrl_fsm;

    localparam int LIMIT = 4;
    localparam int K_ALU_R = 0, K_ALU_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5,
                   K_J = 6, K_JAL = 7, K_JR = 8, K_ILL = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        mem_ready = 1'b0, alu_zero = 1'b0, alu_overflow = 1'b0;
    logic        pc_we, ir_we, mem_rd, mem_wr, mem_addr_sel, mdr_we, aluout_we, alu_ena;
    logic        alu_a_sel, rf_we, illegal, bus_err;
    logic [1:0]  pc_src, alu_b_sel, reg_dst, wb_sel;
    logic [3:0]  aluc;
    logic [2:0]  state_o;
`ifdef OVF_TRAP_EN
    logic        exc_ovf;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.WAIT_W(8), .WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr_sel(mem_addr_sel), .mdr_we(mdr_we), .aluout_we(aluout_we),
        .alu_ena(alu_ena), .aluc(aluc), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .rf_we(rf_we), .reg_dst(reg_dst), .wb_sel(wb_sel), .illegal(illegal),
        .bus_err(bus_err),
`ifdef OVF_TRAP_EN
        .exc_ovf(exc_ovf),
`endif
        .state_o(state_o)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we, mem_rd, mem_wr, mem_addr_sel, mdr_we, aluout_we, alu_ena;
        logic [3:0] aluc;
        logic       alu_a_sel;
        logic [1:0] alu_b_sel;
        logic       rf_we;
        logic [1:0] reg_dst, wb_sel;
        logic       illegal, bus_err, exc_ovf;
    } outs_t;

    typedef struct {
        logic  ready, zero, ovf;
        outs_t exp, care;
    } cyc_t;

    typedef struct {
        logic [5:0] op, fn;
        int         kind;
        logic [3:0] aluc;
        logic       a_sh;
        logic [1:0] bsel;
        logic       ovf_op;
    } ent_t;

    ent_t tbl[$];
    cyc_t tr[$];
    int   n_vec = 0, n_bad = 0;

    function automatic void add(input logic [5:0] op, input logic [5:0] fn, input int kind,
                                input logic [3:0] ac, input logic a_sh, input logic [1:0] bs,
                                input logic ov);
        ent_t e;
        e.op = op; e.fn = fn; e.kind = kind; e.aluc = ac; e.a_sh = a_sh; e.bsel = bs; e.ovf_op = ov;
        tbl.push_back(e);
    endfunction

    function automatic bit lookup(input logic [31:0] ins, output ent_t e);
        e = tbl[0];
        foreach (tbl[i])
            if (tbl[i].op == ins[31:26] && (ins[31:26] != 6'd0 || tbl[i].fn == ins[5:0])) begin
                e = tbl[i];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic outs_t observe();
        outs_t o;
        o.st = state_o; o.pc_we = pc_we; o.pc_src = pc_src; o.ir_we = ir_we;
        o.mem_rd = mem_rd; o.mem_wr = mem_wr; o.mem_addr_sel = mem_addr_sel;
        o.mdr_we = mdr_we; o.aluout_we = aluout_we; o.alu_ena = alu_ena; o.aluc = aluc;
        o.alu_a_sel = alu_a_sel; o.alu_b_sel = alu_b_sel; o.rf_we = rf_we;
        o.reg_dst = reg_dst; o.wb_sel = wb_sel; o.illegal = illegal; o.bus_err = bus_err;
`ifdef OVF_TRAP_EN
        o.exc_ovf = exc_ovf;
`else
        o.exc_ovf = 1'b0;
`endif
        return o;
    endfunction

    task automatic chk_vec(input string tag, input logic [$bits(outs_t)-1:0] got,
                           input logic [$bits(outs_t)-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Fresh cycle: every strobe must be 0 unless set; selects only checked where meaningful.
    function automatic cyc_t mk(input logic [2:0] st);
        cyc_t c;
        c.ready = 1'($urandom); c.zero = 1'($urandom); c.ovf = 1'($urandom);
        c.exp = '0; c.exp.st = st;
        c.care = '0; c.care.st = '1;
        c.care.pc_we = 1; c.care.ir_we = 1; c.care.mem_rd = 1; c.care.mem_wr = 1;
        c.care.mdr_we = 1; c.care.aluout_we = 1; c.care.alu_ena = 1; c.care.rf_we = 1;
        c.care.illegal = 1; c.care.bus_err = 1; c.care.exc_ovf = 1;
        return c;
    endfunction

    function automatic void add_wait(input logic [2:0] st, input int n, input logic rd,
                                     input logic wr, input logic sel);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = mk(st); c.ready = 1'b0;
            c.exp.mem_rd = rd; c.exp.mem_wr = wr;
            c.exp.mem_addr_sel = sel; c.care.mem_addr_sel = 1'b1;
            tr.push_back(c);
        end
    endfunction

    function automatic void add_timeout(input logic [2:0] st, input logic rd, input logic wr,
                                        input logic sel);
        cyc_t c;
        add_wait(st, LIMIT, rd, wr, sel);
        c = mk(st); c.ready = 1'b0; c.exp.bus_err = 1'b1;
        tr.push_back(c);
    endfunction

    function automatic void build(input logic [31:0] ins, input int fd, input bit ft,
                                  input int md, input bit mt, input logic z, input logic o);
        ent_t e;
        int   kind;
        cyc_t c;
        bit   is_lw;
        kind = lookup(ins, e) ? e.kind : K_ILL;
        is_lw = (kind == K_LW);
        tr.delete();
        if (ft) add_timeout(3'd0, 1'b1, 1'b0, 1'b0);
        add_wait(3'd0, fd, 1'b1, 1'b0, 1'b0);
        c = mk(3'd0); c.ready = 1'b1;
        c.exp.mem_rd = 1; c.care.mem_addr_sel = 1; c.exp.ir_we = 1; c.exp.pc_we = 1;
        c.care.pc_src = 2'b11;
        tr.push_back(c);

        c = mk(3'd1);
        case (kind)
            K_J:   begin c.exp.pc_we = 1; c.exp.pc_src = 2'b10; c.care.pc_src = 2'b11; end
            K_JAL: begin
                c.exp.pc_we = 1; c.exp.pc_src = 2'b10; c.care.pc_src = 2'b11;
                c.exp.rf_we = 1; c.exp.reg_dst = 2'b10; c.exp.wb_sel = 2'b10;
                c.care.reg_dst = 2'b11; c.care.wb_sel = 2'b11;
            end
            K_JR:  begin c.exp.pc_we = 1; c.exp.pc_src = 2'b11; c.care.pc_src = 2'b11; end
            K_ILL: c.exp.illegal = 1;
            default: ;
        endcase
        tr.push_back(c);
        if (kind inside {K_J, K_JAL, K_JR, K_ILL}) return;

        c = mk(3'd2); c.zero = z; c.ovf = o;
        c.exp.alu_ena = 1; c.exp.aluc = e.aluc; c.exp.alu_a_sel = e.a_sh; c.exp.alu_b_sel = e.bsel;
        c.care.aluc = '1; c.care.alu_a_sel = 1; c.care.alu_b_sel = '1;
        if (kind == K_BEQ || kind == K_BNE) begin
            c.exp.pc_we = (kind == K_BEQ) ? z : !z;
            if (c.exp.pc_we) begin c.exp.pc_src = 2'b01; c.care.pc_src = 2'b11; end
            tr.push_back(c);
            return;
        end
        c.exp.aluout_we = 1;
`ifdef OVF_TRAP_EN
        if (e.ovf_op && o) begin
            c.exp.exc_ovf = 1;
            tr.push_back(c);
            return;
        end
`endif
        tr.push_back(c);

        if (kind == K_LW || kind == K_SW) begin
            if (mt) begin
                add_timeout(3'd3, is_lw, !is_lw, 1'b1);
                return;
            end
            add_wait(3'd3, md, is_lw, !is_lw, 1'b1);
            c = mk(3'd3); c.ready = 1'b1;
            c.exp.mem_rd = is_lw; c.exp.mem_wr = !is_lw; c.exp.mdr_we = is_lw;
            c.exp.mem_addr_sel = 1; c.care.mem_addr_sel = 1;
            tr.push_back(c);
            if (!is_lw) return;
        end

        c = mk(3'd4);
        c.exp.rf_we = 1;
        c.exp.reg_dst = (kind == K_ALU_R) ? 2'b01 : 2'b00;
        c.exp.wb_sel  = is_lw ? 2'b01 : 2'b00;
        c.care.reg_dst = 2'b11; c.care.wb_sel = 2'b11;
        tr.push_back(c);
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst = 1'b1;
            mem_ready = 1'($urandom); alu_zero = 1'($urandom); alu_overflow = 1'($urandom);
            @(negedge clk);
            chk_vec("rst", observe(), '0);
            @(posedge clk); #1;
        end
    endtask

    task automatic play(input logic [31:0] ins, input int abort_at, input int id);
        instr = ins;
        for (int i = 0; i < tr.size(); i++) begin
            if (i == abort_at) begin
                do_reset(1 + $urandom_range(1));
                return;
            end
            rst = 1'b0;
            mem_ready = tr[i].ready; alu_zero = tr[i].zero; alu_overflow = tr[i].ovf;
            @(negedge clk);
            chk_vec($sformatf("i%0d.c%0d ins=%h", id, i, ins),
                    observe() & tr[i].care, tr[i].exp & tr[i].care);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        ent_t       e;
        logic [31:0] ins;
        logic [5:0]  lo;
        int          ab, idx;

        add(6'h00, 6'h00, K_ALU_R, 4'b1110, 1, 2'b00, 0);
        add(6'h00, 6'h02, K_ALU_R, 4'b1101, 1, 2'b00, 0);
        add(6'h00, 6'h03, K_ALU_R, 4'b1100, 1, 2'b00, 0);
        add(6'h00, 6'h04, K_ALU_R, 4'b1110, 0, 2'b00, 0);
        add(6'h00, 6'h06, K_ALU_R, 4'b1101, 0, 2'b00, 0);
        add(6'h00, 6'h07, K_ALU_R, 4'b1100, 0, 2'b00, 0);
        add(6'h00, 6'h08, K_JR,    4'b0000, 0, 2'b00, 0);
        add(6'h00, 6'h20, K_ALU_R, 4'b0010, 0, 2'b00, 1);
        add(6'h00, 6'h21, K_ALU_R, 4'b0000, 0, 2'b00, 0);
        add(6'h00, 6'h22, K_ALU_R, 4'b0011, 0, 2'b00, 1);
        add(6'h00, 6'h23, K_ALU_R, 4'b0001, 0, 2'b00, 0);
        add(6'h00, 6'h24, K_ALU_R, 4'b0100, 0, 2'b00, 0);
        add(6'h00, 6'h25, K_ALU_R, 4'b0101, 0, 2'b00, 0);
        add(6'h00, 6'h26, K_ALU_R, 4'b0110, 0, 2'b00, 0);
        add(6'h00, 6'h27, K_ALU_R, 4'b0111, 0, 2'b00, 0);
        add(6'h00, 6'h2a, K_ALU_R, 4'b1011, 0, 2'b00, 0);
        add(6'h00, 6'h2b, K_ALU_R, 4'b1010, 0, 2'b00, 0);
        add(6'h02, 6'h00, K_J,     4'b0000, 0, 2'b00, 0);
        add(6'h03, 6'h00, K_JAL,   4'b0000, 0, 2'b00, 0);
        add(6'h04, 6'h00, K_BEQ,   4'b0011, 0, 2'b00, 0);
        add(6'h05, 6'h00, K_BNE,   4'b0011, 0, 2'b00, 0);
        add(6'h08, 6'h00, K_ALU_I, 4'b0010, 0, 2'b01, 1);
        add(6'h09, 6'h00, K_ALU_I, 4'b0000, 0, 2'b01, 0);
        add(6'h0a, 6'h00, K_ALU_I, 4'b1011, 0, 2'b01, 0);
        add(6'h0b, 6'h00, K_ALU_I, 4'b1010, 0, 2'b01, 0);
        add(6'h0c, 6'h00, K_ALU_I, 4'b0100, 0, 2'b10, 0);
        add(6'h0d, 6'h00, K_ALU_I, 4'b0101, 0, 2'b10, 0);
        add(6'h0e, 6'h00, K_ALU_I, 4'b0110, 0, 2'b10, 0);
        add(6'h0f, 6'h00, K_ALU_I, 4'b1000, 0, 2'b10, 0);
        add(6'h23, 6'h00, K_LW,    4'b0000, 0, 2'b01, 0);
        add(6'h2b, 6'h00, K_SW,    4'b0000, 0, 2'b01, 0);

        @(posedge clk); #1;
        do_reset(3);

        // directed scenarios
        build(32'h00851021, 0, 0, 0, 0, 0, 0); play(32'h00851021, -1, 0);
        build(32'h8C830004, 0, 0, 3, 0, 0, 0); play(32'h8C830004, -1, 1);
        build(32'h10850003, 0, 0, 0, 0, 1, 0); play(32'h10850003, -1, 2);
        build(32'h10850003, 0, 0, 0, 0, 0, 0); play(32'h10850003, -1, 3);
        build(32'h00041080, 1, 0, 0, 0, 0, 0); play(32'h00041080, -1, 4);
        build(32'h3C011234, 2, 0, 0, 0, 0, 0); play(32'h3C011234, -1, 5);
        build(32'h00851021, 0, 1, 0, 0, 0, 0); play(32'h00851021, -1, 6);
        build(32'h8C830004, 0, 0, 0, 1, 0, 0); play(32'h8C830004, -1, 7);
        build(32'h00851020, 0, 0, 0, 0, 0, 1); play(32'h00851020, -1, 8);
        build(32'h14850003, 0, 0, 0, 0, 0, 0); play(32'h14850003, -1, 9);
        build(32'h0C000010, 0, 0, 0, 0, 0, 0); play(32'h0C000010, -1, 10);
        build(32'hFC000000, 0, 0, 0, 0, 0, 0); play(32'hFC000000, -1, 11);
        build(32'hAC830004, 1, 0, 2, 0, 0, 0);
        idx = -1;
        foreach (tr[i]) if (idx < 0 && tr[i].exp.st == 3'd3) idx = i;
        play(32'hAC830004, idx, 12);
        build(32'hAC830004, 0, 0, 1, 0, 0, 0); play(32'hAC830004, -1, 13);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(9) == 0) begin
                ins = 32'hFC000000;
                for (int t = 0; t < 100; t++) begin
                    ins = $urandom;
                    if (!lookup(ins, e)) break;
                end
            end else begin
                e = tbl[$urandom_range(tbl.size() - 1)];
                lo = (e.op == 6'd0) ? e.fn : 6'($urandom);
                ins = {e.op, 20'($urandom), lo};
            end
            build(ins, $urandom_range(LIMIT - 1), ($urandom_range(9) == 0),
                  $urandom_range(LIMIT - 1), ($urandom_range(9) == 0),
                  1'($urandom), 1'($urandom));
            ab = ($urandom_range(19) == 0) ? $urandom_range(tr.size() - 1) : -1;
            play(ins, ab, 100 + n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
